// File: rtl/sfifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow and read-valid strobe. Optional parity: define SFIFO_PARITY_EN.
module sfifo_param #(
   parameter int DW     = 16,
   parameter int AW     = 7,
   parameter int AF_LVL = 120,
   parameter int AE_LVL = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_in,
   input  logic [DW-1:0] din_in,
   input  logic          rd_in,
   input  logic          err_clr,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   output logic          full,
   output logic          empty,
   output logic          afull,
   output logic          aempty,
   output logic [AW:0]   count,
   output logic          ovfl,
`ifdef SFIFO_PARITY_EN
   output logic          perr,
`endif
   output logic          udfl
);

   localparam int DEPTH = 1 << AW;
`ifdef SFIFO_PARITY_EN
   localparam int MW = DW + 1;
`else
   localparam int MW = DW;
`endif

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);

   logic [MW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count_nxt;
   logic          rd_acc, wr_acc, ovfl_set, udfl_set;

   function automatic logic even_par(input logic [DW-1:0] d);
      return ^d;
   endfunction

   assign rd_acc   = rd_in & ~empty;
   // A full FIFO still takes a write when the same edge frees a slot.
   assign wr_acc   = wr_in & (~full | rd_acc);
   assign ovfl_set = wr_in & full & ~rd_acc;
   assign udfl_set = rd_in & empty;

   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + ONE_C;
         2'b01:   count_nxt = count - ONE_C;
         default: count_nxt = count;
      endcase
   end

   // Storage array is never reset; only control and the output register are.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
`ifdef SFIFO_PARITY_EN
         mem[wptr] <= {even_par(din_in), din_in};
`else
         mem[wptr] <= din_in;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         afull    <= 1'b0;
         aempty   <= 1'b1;
         dout     <= '0;
         dout_vld <= 1'b0;
         ovfl     <= 1'b0;
         udfl     <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + AW'(1);
         if (rd_acc) begin
            rptr <= rptr + AW'(1);
            dout <= mem[rptr][DW-1:0];
         end
         dout_vld <= rd_acc;
         count    <= count_nxt;
         full     <= (count_nxt == DEPTH_C);
         empty    <= (count_nxt == '0);
         afull    <= (count_nxt >= AF_C);
         aempty   <= (count_nxt <= AE_C);
         // A fresh error in the clearing cycle takes priority over the clear.
         ovfl     <= ovfl_set | (ovfl & ~err_clr);
         udfl     <= udfl_set | (udfl & ~err_clr);
      end
   end

`ifdef SFIFO_PARITY_EN
   logic par_bad;
   assign par_bad = rd_acc & (even_par(mem[rptr][DW-1:0]) != mem[rptr][DW]);

   always_ff @(posedge clk) begin
      if (rst) perr <= 1'b0;
      else     perr <= par_bad | (perr & ~err_clr);
   end
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// Self-checking bench for sfifo_param: queue-based reference model compared every
// cycle, plus directed literal checks on the scenarios of interest.
module tb_sfifo_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_in = 1'b0;
   logic [15:0] din_in = '0;
   logic        rd_in = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] dout;
   logic        dout_vld, full, empty, afull, aempty, ovfl, udfl;
   logic [7:0]  count;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   sfifo_param #(.DW(16), .AW(7), .AF_LVL(120), .AE_LVL(8)) dut (
      .clk(clk), .rst(rst), .wr_in(wr_in), .din_in(din_in), .rd_in(rd_in),
      .err_clr(err_clr), .dout(dout), .dout_vld(dout_vld), .full(full),
      .empty(empty), .afull(afull), .aempty(aempty), .count(count),
      .ovfl(ovfl), .udfl(udfl)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue of stored words plus the visible registers.
   logic [15:0] m_q[$];
   logic [15:0] m_dout = '0;
   bit          m_vld = 0, m_ovfl = 0, m_udfl = 0;

   always @(posedge clk) begin
      int  n;
      bit  rd_ok, wr_ok, o_set, u_set;
      if (rst) begin
         m_q.delete();
         m_dout = '0; m_vld = 0; m_ovfl = 0; m_udfl = 0;
      end else begin
         n     = m_q.size();
         rd_ok = rd_in && (n > 0);
         wr_ok = wr_in && ((n < 128) || rd_ok);
         o_set = wr_in && (n == 128) && !rd_ok;
         u_set = rd_in && (n == 0);
         if (rd_ok) m_dout = m_q.pop_front();
         m_vld = rd_ok;
         if (wr_ok) m_q.push_back(din_in);
         m_ovfl = o_set || (m_ovfl && !err_clr);
         m_udfl = u_set || (m_udfl && !err_clr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         n = m_q.size();
         chk("m_count",  32'(count),    32'(n));
         chk("m_full",   32'(full),     32'(n == 128));
         chk("m_empty",  32'(empty),    32'(n == 0));
         chk("m_afull",  32'(afull),    32'(n >= 120));
         chk("m_aempty", 32'(aempty),   32'(n <= 8));
         chk("m_dout",   32'(dout),     32'(m_dout));
         chk("m_vld",    32'(dout_vld), 32'(m_vld));
         chk("m_ovfl",   32'(ovfl),     32'(m_ovfl));
         chk("m_udfl",   32'(udfl),     32'(m_udfl));
      end
   end

   task automatic step(input bit w, input logic [15:0] d, input bit r, input bit c);
      wr_in = w; din_in = d; rd_in = r; err_clr = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset, then idle.
      #1;
      rst = 1'b1;
      step(0, 16'h0, 0, 0);
      rst = 1'b0;
      chk_en = 1'b1;
      for (int i = 0; i < 5; i++) step(0, 16'h0, 0, 0);
      chk("rst_count",  32'(count),  32'd0);
      chk("rst_empty",  32'(empty),  32'd1);
      chk("rst_aempty", 32'(aempty), 32'd1);
      chk("rst_full",   32'(full),   32'd0);
      chk("rst_dout",   32'(dout),   32'h0);
      chk("rst_errs",   32'({ovfl, udfl}), 32'd0);

      // Fill with 0..127, watching afull threshold and full.
      for (int i = 0; i < 128; i++) begin
         step(1, 16'(i), 0, 0);
         if (i == 118) chk("afull_119", 32'(afull), 32'd0);
         if (i == 119) chk("afull_120", 32'(afull), 32'd1);
         if (i == 126) chk("full_127",  32'(full),  32'd0);
      end
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_count", 32'(count), 32'd128);
      for (int i = 0; i < 128; i++) begin
         step(0, 16'h0, 1, 0);
         chk("drain_dout", 32'(dout), 32'(i));
         chk("drain_vld",  32'(dout_vld), 32'd1);
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Overflow on a full FIFO, then clear.
      for (int i = 0; i < 128; i++) step(1, 16'h0100 + 16'(i), 0, 0);
      step(1, 16'hDEAD, 0, 0);
      chk("ovfl_set",   32'(ovfl),  32'd1);
      chk("ovfl_count", 32'(count), 32'd128);
      step(0, 16'h0, 0, 1);
      chk("ovfl_clr",   32'(ovfl),  32'd0);

      // Simultaneous read and write while full.
      step(1, 16'hBEEF, 1, 0);
      chk("rw_full_count", 32'(count), 32'd128);
      chk("rw_full_ovfl",  32'(ovfl),  32'd0);
      chk("rw_full_dout",  32'(dout),  32'h0100);
      for (int i = 0; i < 128; i++) begin
         step(0, 16'h0, 1, 0);
         chk("rw_drain", 32'(dout), (i < 127) ? 32'h0101 + 32'(i) : 32'hBEEF);
      end

      // Underflow with simultaneous write; no bypass.
      step(1, 16'h1234, 1, 0);
      chk("udfl_set",   32'(udfl),     32'd1);
      chk("udfl_vld",   32'(dout_vld), 32'd0);
      chk("udfl_count", 32'(count),    32'd1);
      step(0, 16'h0, 1, 0);
      chk("udfl_dout",  32'(dout),     32'h1234);
      chk("udfl_vld2",  32'(dout_vld), 32'd1);
      // New underflow in the clearing cycle keeps the flag set.
      step(0, 16'h0, 1, 1);
      chk("udfl_setwins", 32'(udfl), 32'd1);
      step(0, 16'h0, 0, 1);
      chk("udfl_clr",     32'(udfl), 32'd0);

      // Random interleaved traffic across pointer wrap, with a mid-run reset.
      for (int i = 0; i < 64; i++) step(1, 16'($urandom), 0, 0);
      for (int i = 0; i < 200; i++) begin
         bit w, r;
         int sz;
         sz = m_q.size();
         w = 1'($urandom);
         r = 1'($urandom);
         if (sz >= 126) begin w = 0; r = 1; end
         if (sz <= 2)   begin w = 1; r = 0; end
         if (i == 100) begin
            rst = 1'b1;
            step(1, 16'hAAAA, 1, 0);
            rst = 1'b0;
            chk("mid_rst_count", 32'(count),    32'd0);
            chk("mid_rst_empty", 32'(empty),    32'd1);
            chk("mid_rst_dout",  32'(dout),     32'h0);
            chk("mid_rst_vld",   32'(dout_vld), 32'd0);
            chk("mid_rst_full",  32'(full),     32'd0);
         end else begin
            step(w, 16'($urandom), r, 0);
         end
      end

      step(0, 16'h0, 0, 0);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
